// File: rtl/frame_capture_if.sv
// Pixel-side and frame-buffer-side signals of the single-shot frame grabber.
// The master drives the pixel stream; the slave is the grabber itself.
interface frame_capture_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              arm;
    logic              frame_start;
    logic              frame_end;
    logic              line_start;
    logic              pixel_valid;
    logic [7:0]        pixel_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;
    logic              done;
    logic [8:0]        lines;
    logic              resync;

    modport master (
        output arm, frame_start, frame_end, line_start, pixel_valid, pixel_data,
        input  wr_en, wr_addr, wr_data, busy, done, lines, resync
    );

    modport slave (
        input  arm, frame_start, frame_end, line_start, pixel_valid, pixel_data,
        output wr_en, wr_addr, wr_data, busy, done, lines, resync
    );
endinterface

// File: rtl/frame_capture.sv
// Single-shot frame grabber: once armed, writes one frame of pixel bytes
// to a WIDTH x HEIGHT linear buffer at y*WIDTH+x, then reports done.
module frame_capture #(
    parameter int unsigned WIDTH  = 640,
    parameter int unsigned HEIGHT = 480,
    parameter int unsigned ADDR_W = 19
) (
    input  logic           clk,
    input  logic           reset,
    frame_capture_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    localparam logic [9:0]        W_X = 10'(WIDTH);
    localparam logic [8:0]        H_Y = 9'(HEIGHT);
    localparam logic [ADDR_W-1:0] W_A = ADDR_W'(WIDTH);

    state_t            r_state;
    logic [9:0]        r_x;
    logic [8:0]        r_y;
    logic [ADDR_W-1:0] r_line_base;
    logic              r_first_line;
    logic [8:0]        r_lines;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_busy;
    logic              r_done;
    logic              r_resync;

    logic [9:0]        w_x;
    logic [8:0]        w_y;
    logic [ADDR_W-1:0] w_base;
    logic              w_first;
    logic [8:0]        w_lines;
    logic              w_wr;

    // line_start is applied first so a same-cycle pixel lands at x=0 of the new line
    always_comb begin
        w_x     = r_x;
        w_y     = r_y;
        w_base  = r_line_base;
        w_first = r_first_line;
        w_lines = r_lines;
        if (bus.line_start) begin
            w_x = '0;
            if (r_first_line) begin
                w_first = 1'b0;
                w_lines = 9'd1;
            end else begin
                if (r_y < H_Y) begin
                    w_y    = r_y + 9'd1;
                    w_base = r_line_base + W_A;
                end
                if (r_lines < H_Y) w_lines = r_lines + 9'd1;
            end
        end
        w_wr = bus.pixel_valid && (w_x < W_X) && (w_y < H_Y) && !w_first;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_line_base  <= '0;
            r_first_line <= 1'b1;
            r_lines      <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_resync     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.arm) begin
                        r_state <= ARMED;
                        r_busy  <= 1'b1;
                    end
                end
                ARMED: begin
                    if (bus.frame_start) begin
                        r_state      <= CAPTURE;
                        r_x          <= '0;
                        r_y          <= '0;
                        r_line_base  <= '0;
                        r_first_line <= 1'b1;
                        r_lines      <= '0;
                    end
                end
                CAPTURE: begin
                    if (bus.frame_start) begin
                        r_x          <= '0;
                        r_y          <= '0;
                        r_line_base  <= '0;
                        r_first_line <= 1'b1;
                        r_lines      <= '0;
                        r_resync     <= 1'b1;
                    end else begin
                        r_x          <= (bus.pixel_valid && (w_x < W_X)) ? w_x + 10'd1 : w_x;
                        r_y          <= w_y;
                        r_line_base  <= w_base;
                        r_first_line <= w_first;
                        r_lines      <= w_lines;
                        if (w_wr) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= w_base + ADDR_W'(w_x);
                            r_wr_data <= bus.pixel_data;
                        end
                        if (bus.frame_end) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.arm) begin
                        r_state  <= ARMED;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_lines  <= '0;
                        r_resync <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.lines   = r_lines;
    assign bus.resync  = r_resync;
endmodule

// File: tb/tb_frame_capture.sv
// Directed and randomized frames against a geometric model of the buffer:
// a pixel (line l, column c) must land at l*W+c when l<H and c<W.
module tb_frame_capture;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 3;
    localparam int unsigned AW = 4;

    logic clk = 1'b0;
    logic reset;

    frame_capture_if #(.ADDR_W(AW)) bus ();

    frame_capture #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [11:0] exp_q[$];
    logic [11:0] act_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.arm         = 1'b0;
        bus.frame_start = 1'b0;
        bus.frame_end   = 1'b0;
        bus.line_start  = 1'b0;
        bus.pixel_valid = 1'b0;
        bus.pixel_data  = 8'h00;
    endtask

    // One clock: inputs set beforehand are consumed, outputs sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (bus.wr_en === 1'b1) act_q.push_back({bus.wr_addr, bus.wr_data});
        clear_inputs();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_wr_en"},   32'(bus.wr_en),   32'(0));
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'(0));
        chk({tag, "_wr_data"}, 32'(bus.wr_data), 32'(0));
        chk({tag, "_busy"},    32'(bus.busy),    32'(0));
        chk({tag, "_done"},    32'(bus.done),    32'(0));
        chk({tag, "_lines"},   32'(bus.lines),   32'(0));
        chk({tag, "_resync"},  32'(bus.resync),  32'(0));
    endtask

    task automatic chk_status(input string tag, input int busy, input int done,
                              input int resync, input int lines);
        chk({tag, "_busy"},   32'(bus.busy),   32'(busy));
        chk({tag, "_done"},   32'(bus.done),   32'(done));
        chk({tag, "_resync"}, 32'(bus.resync), 32'(resync));
        chk({tag, "_lines"},  32'(bus.lines),  32'(lines));
    endtask

    task automatic compare_writes(input string tag);
        chk({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            chk({tag, "_write"}, 32'(act_q[i]), 32'(exp_q[i]));
        act_q.delete();
        exp_q.delete();
    endtask

    // nl lines of np pixels (np<0: random 0..6 per line). cap: grabber is capturing.
    // rnd: random data, else 16*line+col. lsp: first pixel shares the line_start cycle.
    // fep: frame_end rides on the final pixel (or is sent alone if the last line is empty).
    task automatic do_lines(input int nl, input int np, input bit cap, input bit rnd,
                            input bit lsp, input bit fep);
        bit fe_sent = 1'b0;
        for (int l = 0; l < nl; l++) begin
            int n;
            logic [7:0] d;
            n = (np < 0) ? int'($urandom_range(0, 6)) : np;
            bus.line_start = 1'b1;
            if (!(lsp && n > 0)) cyc();
            for (int c = 0; c < n; c++) begin
                bit last;
                d = rnd ? 8'($urandom) : 8'(16 * l + c);
                last = fep && (l == nl - 1) && (c == n - 1);
                bus.pixel_valid = 1'b1;
                bus.pixel_data  = d;
                if (last) bus.frame_end = 1'b1;
                if (cap && l < int'(H) && c < int'(W))
                    exp_q.push_back({4'(l * int'(W) + c), d});
                cyc();
                if (last) begin
                    fe_sent = 1'b1;
                    chk("done_with_last_write", 32'(bus.done), 32'(cap));
                end
                if ($urandom_range(0, 2) == 0) cyc();
            end
        end
        if (fep && !fe_sent) begin
            bus.frame_end = 1'b1;
            cyc();
        end
    endtask

    initial begin
        int nl;
        bit lsp;
        bit fep;

        clear_inputs();
        reset = 1'b1;
        repeat (2) cyc();
        chk_zero("reset");
        reset = 1'b0;
        cyc();

        // Full frame with directed data
        bus.arm = 1'b1;
        cyc();
        chk_status("armed", 1, 0, 0, 0);
        bus.frame_start = 1'b1;
        cyc();
        do_lines(3, 4, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.frame_end = 1'b1;
        cyc();
        compare_writes("full");
        chk_status("full", 0, 1, 0, 3);
        cyc();
        chk_status("done_hold", 0, 1, 0, 3);

        // Over-size frame: 5 lines of 6 pixels
        bus.arm = 1'b1;
        cyc();
        chk_status("rearm", 1, 0, 0, 0);
        bus.frame_start = 1'b1;
        cyc();
        do_lines(5, 6, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc();
        compare_writes("oversize");
        chk_status("oversize", 0, 1, 0, 3);

        // Frame without arm from IDLE
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        act_q.delete();
        cyc();
        bus.frame_start = 1'b1;
        cyc();
        do_lines(3, 4, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc();
        compare_writes("noarm");
        chk_status("noarm", 0, 0, 0, 0);

        // Arm mid-frame: rest of this frame ignored, next one captured
        bus.frame_start = 1'b1;
        cyc();
        do_lines(1, 4, 1'b0, 1'b1, 1'b0, 1'b0);
        bus.arm = 1'b1;
        cyc();
        do_lines(2, 4, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc();
        compare_writes("midarm_ignored");
        chk_status("midarm_ignored", 1, 0, 0, 0);
        bus.frame_start = 1'b1;
        cyc();
        do_lines(3, 4, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc();
        compare_writes("midarm_capture");
        chk_status("midarm_capture", 0, 1, 0, 3);

        // Resync: second frame_start after two lines
        bus.arm = 1'b1;
        cyc();
        bus.frame_start = 1'b1;
        cyc();
        do_lines(2, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        chk_status("before_resync", 1, 0, 0, 2);
        bus.frame_start = 1'b1;
        cyc();
        chk_status("at_resync", 1, 0, 1, 0);
        do_lines(3, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        bus.frame_end = 1'b1;
        cyc();
        compare_writes("resync");
        chk_status("resync", 0, 1, 1, 3);
        bus.arm = 1'b1;
        cyc();
        chk_status("arm_clears", 1, 0, 0, 0);

        // line_start and pixel in the same cycle
        bus.frame_start = 1'b1;
        cyc();
        do_lines(3, 4, 1'b1, 1'b1, 1'b1, 1'b0);
        bus.frame_end = 1'b1;
        cyc();
        compare_writes("ls_pix");
        chk_status("ls_pix", 0, 1, 0, 3);

        // Asynchronous reset mid-line
        bus.arm = 1'b1;
        cyc();
        bus.frame_start = 1'b1;
        cyc();
        bus.line_start = 1'b1;
        cyc();
        bus.pixel_valid = 1'b1;
        bus.pixel_data  = 8'hA5;
        cyc();
        bus.pixel_valid = 1'b1;
        bus.pixel_data  = 8'h5A;
        cyc();
        chk("pre_reset_wr_en", 32'(bus.wr_en), 32'(1));
        chk("pre_reset_wr_addr", 32'(bus.wr_addr), 32'(1));
        #2;
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        cyc();
        reset = 1'b0;
        act_q.delete();
        exp_q.delete();
        cyc();
        bus.arm = 1'b1;
        cyc();
        bus.frame_start = 1'b1;
        cyc();
        do_lines(3, 4, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc();
        compare_writes("after_reset");
        chk_status("after_reset", 0, 1, 0, 3);

        // Randomized frames
        for (int f = 0; f < 12; f++) begin
            nl  = int'($urandom_range(1, 5));
            lsp = 1'($urandom_range(0, 1));
            fep = 1'($urandom_range(0, 1));
            bus.arm = 1'b1;
            cyc();
            bus.frame_start = 1'b1;
            bus.pixel_valid = 1'($urandom_range(0, 1));
            bus.pixel_data  = 8'($urandom);
            cyc();
            do_lines(nl, -1, 1'b1, 1'b1, lsp, fep);
            if (!fep) begin
                bus.frame_end = 1'b1;
                cyc();
            end
            cyc();
            compare_writes("random");
            chk_status("random", 0, 1, 0, (nl < int'(H)) ? nl : int'(H));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_capture.md
# frame_capture

Single-shot frame grabber between the RGB565 pixel stage and the 8-bit frame buffer. Armed by the readout side, it waits for the next CSI-2 frame start and writes exactly one frame of pixel bytes into a WIDTH×HEIGHT linear buffer using address y*WIDTH+x. When the frame ends it reports completion so the UART dump logic can read the buffer. This replaces free-running write counters with frame- and line-aligned addressing.

## Interface
- WIDTH, 640, pixels stored per line (≤1023)
- HEIGHT, 480, lines stored per frame (≤511)
- ADDR_W, 19, buffer address width; WIDTH*HEIGHT ≤ 2^ADDR_W
- clk  in  1  pixel clock (clk73 domain); all logic on its rising edge
- reset  in  1  asynchronous, active-high reset
- arm  in  1  one-cycle request to capture the next frame
- frame_start  in  1  one-cycle pulse from the CSI-2 packet decoder
- frame_end  in  1  one-cycle pulse from the CSI-2 packet decoder
- line_start  in  1  one-cycle pulse from the CSI-2 packet decoder
- pixel_valid  in  1  pixel_data qualifier (rgb_enable, already edge-reduced to one cycle per pixel)
- pixel_data  in  8  pixel byte
- wr_en  out  1  buffer write strobe
- wr_addr  out  ADDR_W  buffer write address
- wr_data  out  8  buffer write data
- busy  out  1  high in ARMED or CAPTURE
- done  out  1  high in DONE; frame in buffer is valid
- lines  out  9  lines started in the last/current capture, saturating at HEIGHT
- resync  out  1  sticky: frame_start arrived during CAPTURE

## Operation
- States: IDLE, ARMED, CAPTURE, DONE. Reset → IDLE.
- IDLE: arm → ARMED. DONE: arm → ARMED and clears done, lines, and resync. Otherwise DONE holds.
- ARMED: frame_start → CAPTURE with x=0, y=0, line_base=0, first_line=1, lines=0. Pixels and line_start are ignored.
- CAPTURE, line_start:
  - If first_line: clear first_line, keep y=0, and set lines=1.
  - Else: y+=1, line_base+=WIDTH, and lines+=1 (saturating at HEIGHT).
  - In both cases x=0.
- CAPTURE, pixel_valid:
  - If x<WIDTH and y<HEIGHT and !first_line: write pixel_data at line_base+x.
  - x increments while x<WIDTH (holds at WIDTH). Out-of-range pixels are dropped silently.
- CAPTURE, frame_end → DONE.
- CAPTURE, frame_start: restart at x=y=0, line_base=0, first_line=1, lines=0; set resync. The state stays CAPTURE.
- arm is ignored in ARMED and CAPTURE.
- Address arithmetic: line_base is an ADDR_W-bit accumulator and no multiplier is used. y stops advancing at HEIGHT, so line_base never exceeds WIDTH*HEIGHT.

## Timing
- wr_en, wr_addr, and wr_data are registered. A write appears 1 cycle after the pixel_valid that produced it. wr_en lasts 1 cycle per pixel.
- Same-cycle line_start and pixel_valid: the line update applies first, and the pixel is written at x=0 of the new line.
- Same-cycle frame_end and pixel_valid: the pixel is written, then the state goes to DONE.
- Same-cycle frame_start and pixel_valid in ARMED: the pixel is dropped.
- done and busy are registered from the state and change 1 cycle after the causing event.
- The last write of a frame is issued the cycle the state enters DONE. done rises together with that final wr_en, so the reader waits at least 1 more cycle.
- Reset (any time, including mid-frame) asynchronously sets:
  - state=IDLE
  - wr_en=0, wr_addr=0, wr_data=0
  - busy=0, done=0, lines=0, resync=0
  - internal x=0, y=0, line_base=0

## Test plan
- Full frame, WIDTH=4, HEIGHT=3:
  - Stimulus: arm, then frame_start, 3×(line_start + 4 pixels of value 16*line+col), then frame_end.
  - Required: 12 writes at addresses 0..11 with matching data, done=1, lines=3, resync=0.
- Over-size input:
  - Stimulus: 6 pixels per line and 5 lines, with WIDTH=4, HEIGHT=3.
  - Required: only 12 writes; highest address 11; lines=3.
- Not armed:
  - Stimulus: a full frame with no arm.
  - Required: no wr_en; state stays IDLE.
  - Stimulus: arm mid-frame.
  - Required: capture begins at the next frame_start.
- Resync:
  - Stimulus: after 2 lines, a second frame_start, then 3 full lines and frame_end.
  - Required: writes restart at address 0; resync=1; done=1.
- Edges:
  - Stimulus: line_start with pixel_valid in the same cycle.
  - Required: the pixel is written at line_base.
  - Stimulus: async reset mid-line.
  - Required: all outputs 0 immediately.
  - Stimulus: a subsequent arm and frame.
  - Required: the capture is correct from address 0.
